fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have parameter HALT_OPC, default 4'b1111: opcode in inst[15:12] that halts fetch.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold request from the hazard unit; freezes PC and IF/ID.
REQ-006 if_flush  input  1  insert a bubble into IF/ID this cycle.
REQ-007 redirect  input  1  taken branch or jump resolved downstream.
REQ-008 redirect_pc  input  16  target PC; valid when redirect=1.
REQ-009 imem_req  output  1  instruction-memory read request.
REQ-010 imem_addr  output  16  equals current PC.
REQ-011 imem_rdy  input  1  imem_data valid this cycle; wait states allowed.
REQ-012 imem_data  input  16  instruction word.
REQ-013 if_id_inst  output  16  registered instruction to decode and the hazard unit.
REQ-014 if_id_pc2  output  16  registered PC+2 of if_id_inst.
REQ-015 if_id_valid  output  1  if_id_inst is a real instruction, not a bubble.
REQ-016 fetch_halted  output  1  FSM is in HALTED.

Function
REQ-017 SHALL implement FSM states RUN and HALTED; reset enters RUN.
REQ-018 In RUN, imem_req SHALL be 1; in HALTED, imem_req SHALL be 0.
REQ-019 Per-cycle priority SHALL be: rst > redirect/if_flush > stall > imem wait > normal advance.
REQ-020 Normal advance (RUN, imem_rdy=1, no stall, no redirect, no if_flush) SHALL load: PC <= PC+2 (mod 2^16, wraps at 16'hFFFE); if_id_inst <= imem_data; if_id_pc2 <= PC+2; if_id_valid <= 1.
REQ-021 redirect=1 SHALL load PC <= redirect_pc and load a bubble into IF/ID, regardless of stall or imem_rdy.
REQ-022 if_flush=1 SHALL load a bubble into IF/ID even when stall=1; the PC follows REQ-021 or REQ-023.
REQ-023 stall=1 with no redirect and no if_flush SHALL hold PC, if_id_inst, if_id_pc2 and if_id_valid unchanged.
REQ-024 imem_rdy=0 in RUN, with no stall and no redirect, SHALL hold the PC and load a bubble into IF/ID.
REQ-025 A bubble SHALL be if_id_inst=NOP_INST (16'h0000), if_id_pc2=16'h0000, if_id_valid=0.
REQ-026 On a normal advance of a word with [15:12]=HALT_OPC: the word enters IF/ID and the FSM goes to HALTED; the PC does not increment.
REQ-027 In HALTED, with no redirect, the PC SHALL hold and IF/ID SHALL hold while stall=1, else load a bubble.
REQ-028 redirect=1 in HALTED (the HLT was in a branch shadow) SHALL return to RUN with PC <= redirect_pc.
REQ-029 Fetch-to-IF/ID latency SHALL be 1 cycle after imem_rdy; imem_addr SHALL be combinational from the PC register.
REQ-030 A redirect during a wait state SHALL abandon the pending address; no stale word enters IF/ID.

Reset
REQ-031 With rst=1 at the edge: PC=RESET_PC, state=RUN, if_id_inst=16'h0000, if_id_pc2=16'h0000, if_id_valid=0, fetch_halted=0.
REQ-032 rst SHALL override every other input, including mid-wait, in HALTED, and with redirect asserted.

Structure
REQ-033 Package cpu_pkg SHALL hold NOP_INST, HALT_OPC, the fetch state enum, and the 16-bit word typedef.
REQ-034 The IF/ID register SHALL be sub-module if_id_reg (ports: load, bubble, hold).

Verification
REQ-035 Reset, imem_rdy=1, words 16'h1123, 16'h2456 -> imem_addr 0000, 0002, 0004; if_id_pc2 0002 then 0004; if_id_valid=1 from cycle 2.
REQ-036 stall=1 for 2 cycles at PC=0x0006 -> PC and if_id_inst frozen for 2 cycles; advance resumes at 0x0006.
REQ-037 redirect=1, redirect_pc=0x0040, with stall=1 and imem_rdy=0 -> next cycle imem_addr=0x0040 and if_id_valid=0.
REQ-038 Fetch 16'hF000 at PC=0x0010 -> fetch_halted=1 next cycle, imem_req=0, imem_addr stays 0x0010; redirect to 0x0020 -> RUN, fetch at 0x0020.
REQ-039 imem_rdy=0 for 3 cycles at PC=0x0008 -> 3 bubbles, PC held; the word at 0x0008 lands on the 4th cycle.
REQ-040 PC=0xFFFE, normal advance -> PC=0x0000, if_id_pc2=0x0000; rst during a wait state -> PC=RESET_PC next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: instruction word, fetch FSM states, NOP and HLT encodings.
package cpu_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_e;

  localparam word_t      NOP_INST = 16'h0000;
  localparam logic [3:0] HALT_OPC = 4'b1111;

  // Instructions are 2 bytes; the PC wraps naturally at 16'hFFFE.
  function automatic word_t pc_next(input word_t pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats load.
// One-cycle register; hold freezes the contents for the hazard unit.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  logic  hold,
  input  word_t inst_in,
  input  word_t pc2_in,
  output word_t inst,
  output word_t pc2,
  output logic  valid
);

  word_t inst_q, inst_d;
  word_t pc2_q, pc2_d;
  logic  valid_q, valid_d;

  always_comb begin
    inst_d  = inst_q;
    pc2_d   = pc2_q;
    valid_d = valid_q;
    if (bubble) begin
      inst_d  = NOP_INST;
      pc2_d   = 16'h0000;
      valid_d = 1'b0;
    end else if (hold) begin
      inst_d  = inst_q;
      pc2_d   = pc2_q;
      valid_d = valid_q;
    end else if (load) begin
      inst_d  = inst_in;
      pc2_d   = pc2_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      pc2_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc2_q   <= pc2_d;
      valid_q <= valid_d;
    end
  end

  assign inst  = inst_q;
  assign pc2   = pc2_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, RUN/HALTED FSM and IF/ID register; word lands in IF/ID one cycle after imem_rdy.
// Priority rst > redirect/if_flush > stall > imem wait > advance; stall freezes everything, wait inserts bubbles.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OPC = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        if_flush,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] if_id_inst,
  output logic [15:0] if_id_pc2,
  output logic        if_id_valid,
  output logic        fetch_halted
);

  import cpu_pkg::word_t;
  import cpu_pkg::fetch_state_e;
  import cpu_pkg::FS_RUN;
  import cpu_pkg::FS_HALTED;
  import cpu_pkg::pc_next;

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  logic         req_q, req_d;
  logic         halted_q, halted_d;

  word_t pc_inc;
  logic  ifid_load;
  logic  ifid_bubble;
  logic  ifid_hold;

  assign pc_inc = pc_next(pc_q);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_hold   = 1'b0;
    if (redirect) begin
      // A pending wait-state address is simply dropped; the bubble keeps any stale word out.
      pc_d        = redirect_pc;
      state_d     = FS_RUN;
      ifid_bubble = 1'b1;
    end else if (if_flush) begin
      ifid_bubble = 1'b1;
    end else if (stall) begin
      ifid_hold = 1'b1;
    end else if (state_q == FS_HALTED) begin
      ifid_bubble = 1'b1;
    end else if (!imem_rdy) begin
      ifid_bubble = 1'b1;
    end else begin
      ifid_load = 1'b1;
      if (imem_data[15:12] == HALT_OPC) begin
        state_d = FS_HALTED;
      end else begin
        pc_d = pc_inc;
      end
    end
    req_d    = (state_d == FS_RUN);
    halted_d = (state_d == FS_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FS_RUN;
      pc_q     <= RESET_PC;
      req_q    <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      halted_q <= halted_d;
    end
  end

  assign imem_addr    = pc_q;
  assign imem_req     = req_q;
  assign fetch_halted = halted_q;

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .hold   (ifid_hold),
    .inst_in(imem_data),
    .pc2_in (pc_inc),
    .inst   (if_id_inst),
    .pc2    (if_id_pc2),
    .valid  (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a behavioural model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        if_flush;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] if_id_inst;
  logic [15:0] if_id_pc2;
  logic        if_id_valid;
  logic        fetch_halted;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the architecturally visible state.
  logic [15:0] m_pc;
  logic        m_halted;
  logic [15:0] m_inst;
  logic [15:0] m_pc2;
  logic        m_valid;

  fetch_stage #(
    .RESET_PC(16'h0000),
    .HALT_OPC(4'b1111)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .if_flush    (if_flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .if_id_inst  (if_id_inst),
    .if_id_pc2   (if_id_pc2),
    .if_id_valid (if_id_valid),
    .fetch_halted(fetch_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_bubble();
    m_inst  = 16'h0000;
    m_pc2   = 16'h0000;
    m_valid = 1'b0;
  endtask

  // Applies one cycle of inputs, advances the model with the same inputs, samples 1 time unit after the edge.
  task automatic drive(input logic r, input logic st, input logic fl, input logic rd,
                       input logic [15:0] rpc, input logic rdy, input logic [15:0] dat);
    rst = r; stall = st; if_flush = fl; redirect = rd;
    redirect_pc = rpc; imem_rdy = rdy; imem_data = dat;
    @(posedge clk);
    if (r) begin
      m_pc = 16'h0000; m_halted = 1'b0; model_bubble();
    end else if (rd) begin
      m_pc = rpc; m_halted = 1'b0; model_bubble();
    end else if (fl) begin
      model_bubble();
    end else if (st) begin
      // everything frozen
    end else if (m_halted || !rdy) begin
      model_bubble();
    end else begin
      m_inst  = dat;
      m_pc2   = 16'((32'(m_pc) + 2) % 65536);
      m_valid = 1'b1;
      if (dat >= 16'hF000) m_halted = 1'b1;
      else m_pc = m_pc2;
    end
    #1;
  endtask

  task automatic advance(input logic [15:0] dat);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, dat);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 16'hABCD);
    total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h want=0000", imem_addr); end
    total++; if (if_id_inst !== 16'h0000) begin bad++; $display("FAIL reset_inst got=%h want=0000", if_id_inst); end
    total++; if (if_id_pc2 !== 16'h0000) begin bad++; $display("FAIL reset_pc2 got=%h want=0000", if_id_pc2); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", if_id_valid); end
    total++; if (fetch_halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", fetch_halted); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_req got=%b want=1", imem_req); end
  endtask

  task automatic test_advance();
    advance(16'h1123);
    total++; if (imem_addr !== 16'h0002) begin bad++; $display("FAIL adv1_addr got=%h want=0002", imem_addr); end
    total++; if (if_id_pc2 !== 16'h0002 || if_id_inst !== 16'h1123 || if_id_valid !== 1'b1) begin
      bad++; $display("FAIL adv1_ifid got=%h/%h/%b want=1123/0002/1", if_id_inst, if_id_pc2, if_id_valid); end
    advance(16'h2456);
    total++; if (imem_addr !== 16'h0004) begin bad++; $display("FAIL adv2_addr got=%h want=0004", imem_addr); end
    total++; if (if_id_pc2 !== 16'h0004 || if_id_inst !== 16'h2456 || if_id_valid !== 1'b1) begin
      bad++; $display("FAIL adv2_ifid got=%h/%h/%b want=2456/0004/1", if_id_inst, if_id_pc2, if_id_valid); end
  endtask

  task automatic test_stall();
    advance(16'h3789);
    total++; if (imem_addr !== 16'h0006) begin bad++; $display("FAIL stall_pre_addr got=%h want=0006", imem_addr); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4000);
      total++; if (imem_addr !== 16'h0006 || if_id_inst !== 16'h3789 || if_id_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold[%0d] got=%h/%h/%b want=0006/3789/1", i, imem_addr, if_id_inst, if_id_valid); end
    end
    advance(16'h4ABC);
    total++; if (imem_addr !== 16'h0008 || if_id_inst !== 16'h4ABC || if_id_pc2 !== 16'h0008) begin
      bad++; $display("FAIL stall_resume got=%h/%h/%h want=0008/4abc/0008", imem_addr, if_id_inst, if_id_pc2); end
  endtask

  task automatic test_wait();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hDEAD);
      total++; if (imem_addr !== 16'h0008 || if_id_valid !== 1'b0 || if_id_inst !== 16'h0000 || if_id_pc2 !== 16'h0000) begin
        bad++; $display("FAIL wait_bubble[%0d] got=%h/%b/%h/%h want=0008/0/0000/0000", i, imem_addr, if_id_valid, if_id_inst, if_id_pc2); end
    end
    advance(16'h5111);
    total++; if (if_id_inst !== 16'h5111 || if_id_pc2 !== 16'h000A || imem_addr !== 16'h000A) begin
      bad++; $display("FAIL wait_land got=%h/%h/%h want=5111/000a/000a", if_id_inst, if_id_pc2, imem_addr); end
  endtask

  task automatic test_redirect();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h1111);
    total++; if (imem_addr !== 16'h0040 || if_id_valid !== 1'b0) begin
      bad++; $display("FAIL redirect got=%h/%b want=0040/0", imem_addr, if_id_valid); end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h2222);
    total++; if (imem_addr !== 16'h0040 || if_id_valid !== 1'b0) begin
      bad++; $display("FAIL flush_stall got=%h/%b want=0040/0", imem_addr, if_id_valid); end
  endtask

  task automatic test_halt();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000);
    advance(16'hF000);
    total++; if (fetch_halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 16'h0010) begin
      bad++; $display("FAIL halt_enter got=%b/%b/%h want=1/0/0010", fetch_halted, imem_req, imem_addr); end
    total++; if (if_id_inst !== 16'hF000 || if_id_valid !== 1'b1 || if_id_pc2 !== 16'h0012) begin
      bad++; $display("FAIL halt_word got=%h/%b/%h want=f000/1/0012", if_id_inst, if_id_valid, if_id_pc2); end
    advance(16'h1234);
    total++; if (fetch_halted !== 1'b1 || imem_addr !== 16'h0010 || if_id_valid !== 1'b0) begin
      bad++; $display("FAIL halt_stay got=%b/%h/%b want=1/0010/0", fetch_halted, imem_addr, if_id_valid); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h0000);
    total++; if (fetch_halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0020) begin
      bad++; $display("FAIL halt_exit got=%b/%b/%h want=0/1/0020", fetch_halted, imem_req, imem_addr); end
    advance(16'h6000);
    total++; if (if_id_inst !== 16'h6000 || if_id_pc2 !== 16'h0022) begin
      bad++; $display("FAIL halt_refetch got=%h/%h want=6000/0022", if_id_inst, if_id_pc2); end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000);
    advance(16'h7000);
    total++; if (imem_addr !== 16'h0000 || if_id_pc2 !== 16'h0000 || if_id_valid !== 1'b1) begin
      bad++; $display("FAIL wrap got=%h/%h/%b want=0000/0000/1", imem_addr, if_id_pc2, if_id_valid); end
    advance(16'h7001);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    total++; if (imem_addr !== 16'h0000 || if_id_valid !== 1'b0) begin
      bad++; $display("FAIL rst_in_wait got=%h/%b want=0000/0", imem_addr, if_id_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      logic r, st, fl, rd, rdy;
      logic [15:0] rpc, dat;
      r   = ($urandom_range(0, 63) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      fl  = ($urandom_range(0, 11) == 0);
      st  = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = 16'($urandom) & 16'hFFFE;
      dat = 16'($urandom);
      drive(r, st, fl, rd, rpc, rdy, dat);
      total++;
      if (imem_addr !== m_pc || imem_req !== !m_halted || fetch_halted !== m_halted ||
          if_id_inst !== m_inst || if_id_pc2 !== m_pc2 || if_id_valid !== m_valid) begin
        bad++;
        $display("FAIL random[%0d] got addr=%h req=%b halt=%b inst=%h pc2=%h v=%b want addr=%h req=%b halt=%b inst=%h pc2=%h v=%b",
                 i, imem_addr, imem_req, fetch_halted, if_id_inst, if_id_pc2, if_id_valid,
                 m_pc, !m_halted, m_halted, m_inst, m_pc2, m_valid);
      end
    end
  endtask

  initial begin
    m_pc = 16'h0000; m_halted = 1'b0; m_inst = 16'h0000; m_pc2 = 16'h0000; m_valid = 1'b0;
    rst = 1'b1; stall = 1'b0; if_flush = 1'b0; redirect = 1'b0;
    redirect_pc = 16'h0000; imem_rdy = 1'b0; imem_data = 16'h0000;
    test_reset();
    test_advance();
    test_stall();
    test_wait();
    test_redirect();
    test_halt();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
